dmem_bridge: RTL
================

# dmem_bridge

Converts the datapath's level-held data-memory port (`den`/`dwt`/`daddr`/`dwd`/`dsize` in, `drd`/`ddataOK` out) into a single-outstanding SRAM-like bus transaction with separate address and data handshakes. It sits directly downstream of the datapath, between the commit stage's memory port and the data-side cache/AXI adapter. It also performs fixed kseg0/kseg1 virtual-to-physical translation and flags uncached accesses.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `den`  in  1  datapath access request; held high until `ddataOK`.
- `dwt`  in  1  1 = store, 0 = load.
- `daddr`  in  32  virtual byte address.
- `dwd`  in  32  store data, already lane-aligned by commit.
- `dsize`  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- `drd`  out  32  load data; valid while `ddataOK` = 1.
- `ddataOK`  out  1  one-cycle completion pulse.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  bus write.
- `data_size`  out  2  copy of the captured `dsize`.
- `data_addr`  out  32  physical address.
- `data_wdata`  out  32  captured `dwd`.
- `data_uncached`  out  1  1 when the captured address is in kseg1.
- `data_addr_ok`  in  1  bus accepted the address phase.
- `data_data_ok`  in  1  bus completed the data phase.
- `data_rdata`  in  32  bus read data; valid with `data_data_ok`.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DONE.
- **IDLE**
  - `den` = 1 captures `dwt`, translated address, `dwd`, `dsize` and the uncached flag into holding registers, then moves to REQ.
  - `den` = 0 stays in IDLE.
- **REQ**
  - `data_req` = 1; all `data_*` outputs come from the holding registers and stay stable.
  - `data_addr_ok` = 1 with `data_data_ok` = 1 goes to DONE.
  - `data_addr_ok` = 1 alone goes to WAIT.
  - Neither signal high stays in REQ.
  - `data_data_ok` without `data_addr_ok` is ignored.
- **WAIT**
  - `data_req` = 0.
  - `data_data_ok` = 1 goes to DONE; otherwise stay in WAIT.
- **Data capture:** on the `data_data_ok` cycle, a load registers `data_rdata` into `drd`. A store leaves `drd` unchanged.
- **DONE**
  - `ddataOK` = 1 for exactly this one cycle, then return to IDLE.
  - `den` is ignored in DONE, because it still belongs to the completed access.
  - The first IDLE cycle after DONE samples `den` as a new access, so back-to-back accesses are supported.
- **Address translation:**
  - `daddr[31:29]` = 3'b100 (kseg0) or 3'b101 (kseg1): physical address = {3'b000, `daddr[28:0]`}.
  - All other segments: identity mapping (no TLB).
  - `data_uncached` = 1 only for kseg1.
- **Boundary cases:**
  - `data_data_ok` in IDLE or DONE is ignored.
  - `den` dropping while in REQ or WAIT does not abort the transaction; it completes and still pulses `ddataOK`.
  - Changes to `daddr`/`dwd` after capture have no effect.
  - Reset is asynchronous and may assert mid-transaction. The FSM goes to IDLE and every output goes to 0, including `drd` and the holding registers. A stale `data_data_ok` arriving later is ignored.

## Timing
- Minimum latency, with `addr_ok` and `data_ok` both in the first REQ cycle:
  - cycle 0: `den` sampled;
  - cycle 1: REQ, handshake completes;
  - cycle 2: `ddataOK` = 1.
- General latency is 2 + (REQ wait cycles) + (WAIT cycles).
- `data_req` is a registered-state decode; there is no combinational path from `den` to any `data_*` output.
- `ddataOK` and `drd` are registered; there is no combinational path from `data_data_ok`/`data_rdata`.
- At most one transaction is outstanding at any time.

## Structure
- Shared package (`mips.svh`) holds:
  - the `dsize` encoding constants (byte/half/word);
  - the KSEG0/KSEG1 segment constants;
  - a `dmem_state_t` enum for IDLE/REQ/WAIT/DONE.
- One sub-module, `dmem_addr_translate`, is combinational:
  - input: `vaddr`;
  - outputs: `paddr` and `uncached`.
- The FSM, holding registers and response registers live in `dmem_bridge`.

## Test plan
- **Single load:** `den` = 1, `dwt` = 0, `daddr` = 0x8000_1004, `dsize` = 2; bus holds `addr_ok` and `data_ok` in cycle 1 with `data_rdata` = 0xDEAD_BEEF. Required: `data_addr` = 0x0000_1004, `data_uncached` = 0, `ddataOK` pulses in cycle 2 with `drd` = 0xDEAD_BEEF.
- **Uncached store with slow handshake:** `daddr` = 0xBFC0_0010, `dwt` = 1, `dwd` = 0x1234_5678, `dsize` = 0; `addr_ok` after 3 cycles, then `data_ok` 2 cycles later. Required: `data_req` high for exactly 4 cycles, `data_addr` = 0x1FC0_0010, `data_uncached` = 1, one `ddataOK` pulse, `drd` unchanged.
- **Back-to-back:** `den` is held high across two loads (0x8000_0000, then 0x8000_0004). Required: exactly two bus requests, two `ddataOK` pulses, and no duplicate request issued during DONE.
- **kuseg identity:** load at 0x0040_0000 -> `data_addr` = 0x0040_0000, `data_uncached` = 0.
- **Reset mid-transaction:** reset asserts while in WAIT, then `data_data_ok` arrives after release with `den` = 0. Required: all outputs 0 immediately, `ddataOK` never pulses, FSM stays in IDLE.
- **Spurious response:** `data_data_ok` pulses in IDLE. Required: no `ddataOK` pulse and `drd` unchanged.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: size encodings, MIPS segment
// constants and the bridge FSM state encoding.
package dmem_bridge_pkg;

    localparam logic [1:0] DSIZE_BYTE = 2'd0;
    localparam logic [1:0] DSIZE_HALF = 2'd1;
    localparam logic [1:0] DSIZE_WORD = 2'd2;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_REQ  = 2'd1,
        DMEM_WAIT = 2'd2,
        DMEM_DONE = 2'd3
    } dmem_state_t;

    // Everything the bus side needs, frozen at the moment the access is accepted.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uncached;
    } dmem_hold_t;

endpackage

// File: rtl/dmem_addr_translate.sv
// Fixed MIPS virtual-to-physical mapping: kseg0/kseg1 fold onto the low 512 MB,
// every other segment passes through unchanged.
module dmem_addr_translate
    import dmem_bridge_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr,
    output logic        uncached
);

    logic [2:0] seg;

    assign seg = vaddr[31:29];

    always_comb begin
        paddr    = vaddr;
        uncached = 1'b0;
        if (seg == SEG_KSEG0 || seg == SEG_KSEG1) begin
            paddr = {3'b000, vaddr[28:0]};
        end
        if (seg == SEG_KSEG1) begin
            uncached = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Turns the datapath's level-held memory request into one SRAM-like bus
// transaction with separate address and data phases, one outstanding at a time.
module dmem_bridge
    import dmem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        den,
    input  logic        dwt,
    input  logic [31:0] daddr,
    input  logic [31:0] dwd,
    input  logic [1:0]  dsize,
    output logic [31:0] drd,
    output logic        ddataOK,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic        data_uncached,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: data_req stays high and data_* stay stable until data_addr_ok;
    // data_data_ok only counts once the address phase has been accepted.
    localparam logic [1:0] S_IDLE = DMEM_IDLE;
    localparam logic [1:0] S_REQ  = DMEM_REQ;
    localparam logic [1:0] S_WAIT = DMEM_WAIT;
    localparam logic [1:0] S_DONE = DMEM_DONE;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    dmem_hold_t  hold_q;
    logic [31:0] drd_q;
    logic [31:0] xlat_paddr;
    logic        xlat_uncached;
    logic        capture;
    logic        resp_fire;

    dmem_addr_translate u_xlat (
        .vaddr    (daddr),
        .paddr    (xlat_paddr),
        .uncached (xlat_uncached)
    );

    assign capture   = (state == S_IDLE) && den;
    assign resp_fire = ((state == S_REQ) && data_addr_ok && data_data_ok) ||
                       ((state == S_WAIT) && data_data_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (den) state_nxt = S_REQ;
            S_REQ: begin
                if (data_addr_ok) begin
                    state_nxt = data_data_ok ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: if (data_data_ok) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q.wr       <= dwt;
            hold_q.size     <= dsize;
            hold_q.addr     <= xlat_paddr;
            hold_q.wdata    <= dwd;
            hold_q.uncached <= xlat_uncached;
        end
    end

    // Stores complete without touching drd so the last load value survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drd_q <= '0;
        end else if (resp_fire && !hold_q.wr) begin
            drd_q <= data_rdata;
        end
    end

    assign drd           = drd_q;
    assign ddataOK       = (state == S_DONE);
    assign data_req      = (state == S_REQ);
    assign data_wr       = hold_q.wr;
    assign data_size     = hold_q.size;
    assign data_addr     = hold_q.addr;
    assign data_wdata    = hold_q.wdata;
    assign data_uncached = hold_q.uncached;
    assign dbg_state     = state;

endmodule
